// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the instruction prefetcher.
// Holds the fetch FSM encoding, lane-count derivation and a log2 helper
// used to size queue pointers, counters and lane counters.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_WAIT_SLOT = 2'd2
    } fetch_state_e;

    // ceil(log2(n)), but never less than 1 so a one-entry structure still gets a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of memory beats that make up one instruction
    function automatic int lanes_of(input int width, input int instr_bits);
        return instr_bits / width;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: synchronous FIFO holding {pc, instruction} entries.
// Latency: a push is visible at the head (empty_o low) the cycle after.
// Backpressure: push is ignored when full without a pop; flush beats push and pop.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int DW    = 40,
    parameter int DEPTH = 2,
    parameter int CNT_W = clog2_min1(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [DW-1:0]    push_dat_i,
    input  logic             pop_i,
    output logic [DW-1:0]    pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = clog2_min1(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);

    // Pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: autonomous prefetcher assembling INSTR_BITS words from WIDTH-bit beats.
// Latency: lane-0 request to instr_valid is LANES+1 cycles; one instruction per LANES cycles.
// Backpressure: a new instruction starts only when queue + in-assembly < DEPTH; else fetch waits.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               INSTR_BITS = 32,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic                  mem_req,
    output logic [WIDTH-1:0]      mem_adr,
    input  logic [WIDTH-1:0]      memdata,
    output logic [INSTR_BITS-1:0] instr,
    output logic [WIDTH-1:0]      instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [WIDTH-1:0]      redirect_pc
);
    localparam int                LANES     = lanes_of(WIDTH, INSTR_BITS);
    localparam int                LANE_W    = clog2_min1(LANES);
    localparam int                QDW       = INSTR_BITS + WIDTH;
    localparam int                CNT_W     = clog2_min1(DEPTH + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    fetch_state_e          state_q;
    logic [WIDTH-1:0]      fetch_pc_q;
    logic [LANE_W-1:0]     lane_q;
    logic [WIDTH-1:0]      start_pc_q;
    logic [INSTR_BITS-1:0] asm_q;
    logic                  busy_q;
    logic                  rsp_vld_q;
    logic [LANE_W-1:0]     rsp_lane_q;

    logic [INSTR_BITS-1:0] asm_d;
    logic                  slot_free;
    logic                  final_cap;
    logic                  q_push;
    logic                  q_pop;
    logic [QDW-1:0]        q_head;
    logic                  q_full;
    logic                  q_empty;
    logic [CNT_W-1:0]      q_count;

    // A pop in this cycle is deliberately not counted: only registered occupancy is used
    assign slot_free = !q_full && ((int'(q_count) + int'(busy_q)) < DEPTH);

    assign mem_req   = (state_q == ST_FETCH) && !redirect && !reset;
    assign mem_adr   = fetch_pc_q;

    // The final beat completes the word; a redirect this cycle squashes it
    assign final_cap = rsp_vld_q && (rsp_lane_q == LAST_LANE) && !redirect;
    assign q_push    = final_cap && !reset;
    assign q_pop     = instr_valid && instr_ready && !redirect;

    assign instr_valid = !q_empty;
    assign instr       = instr_valid ? q_head[INSTR_BITS-1:0] : '0;
    assign instr_pc    = instr_valid ? q_head[QDW-1:INSTR_BITS] : '0;

    // Merge the arriving beat into its lane of the assembly word
    always_comb begin
        asm_d = asm_q;
        asm_d[int'(rsp_lane_q) * WIDTH +: WIDTH] = memdata;
    end

    // Request addressing, response capture and in-assembly tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            lane_q     <= '0;
            start_pc_q <= '0;
            asm_q      <= '0;
            busy_q     <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_lane_q <= '0;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            lane_q     <= '0;
            asm_q      <= '0;
            busy_q     <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_lane_q <= '0;
        end else begin
            rsp_vld_q  <= mem_req;
            rsp_lane_q <= lane_q;
            if (mem_req) begin
                fetch_pc_q <= fetch_pc_q + 1'b1;
                lane_q     <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
                if (lane_q == '0) start_pc_q <= fetch_pc_q;
            end
            if (rsp_vld_q) asm_q <= asm_d;
            busy_q <= (busy_q && !final_cap) || (mem_req && (lane_q == '0));
        end
    end

    // Fetch FSM: decides at the last-lane request whether the next word may start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (redirect) begin
            state_q <= fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_en && slot_free) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (lane_q == LAST_LANE) begin
                        if (fetch_en && slot_free) state_q <= ST_FETCH;
                        else if (fetch_en)         state_q <= ST_WAIT_SLOT;
                        else                       state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (!fetch_en)      state_q <= ST_IDLE;
                    else if (slot_free) state_q <= ST_FETCH;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DW    (QDW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst_i      (reset),
        .flush_i    (redirect),
        .push_i     (q_push),
        .push_dat_i ({start_pc_q, asm_d}),
        .pop_i      (q_pop),
        .pop_dat_o  (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run.
// The reference model treats the DUT as a stream: sequential request addresses,
// in-order instructions built from memory bytes, and at most DEPTH words held.
module tb_instr_fetch_unit;
    localparam int         WIDTH    = 8;
    localparam int         IBITS    = 32;
    localparam int         DEPTH    = 2;
    localparam int         LANES    = IBITS / WIDTH;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        mem_req;
    logic [7:0]  mem_adr;
    logic [7:0]  memdata = 8'h00;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    logic [7:0]  mem [256];
    int          vec  = 0;
    int          errs = 0;
    int          pops = 0;

    // reference stream state
    logic [7:0]  nadr = RESET_PC;
    logic [7:0]  epc  = RESET_PC;
    int          grp  = 0;
    int          held = 0;

    instr_fetch_unit #(
        .WIDTH      (WIDTH),
        .INSTR_BITS (IBITS),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .mem_req     (mem_req),
        .mem_adr     (mem_adr),
        .memdata     (memdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory: data for an accepted request appears the following cycle; junk otherwise
    always @(posedge clk) begin
        memdata <= mem_req ? mem[mem_adr] : 8'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vec++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] pc);
        logic [31:0] w;
        logic [7:0]  a;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            a = 8'(int'(pc) + k);
            w[k*8 +: 8] = mem[a];
        end
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Stream-level monitor: addresses, delivered words and occupancy bound
    always @(negedge clk) begin
        if (reset) begin
            nadr = RESET_PC; epc = RESET_PC; grp = 0; held = 0;
        end else if (redirect) begin
            chk("redirect_req_low", mem_req, 1'b0);
            nadr = redirect_pc; epc = redirect_pc; grp = 0; held = 0;
        end else begin
            if (mem_req) begin
                chk("req_adr", mem_adr, nadr);
                nadr = nadr + 8'd1;
                grp++;
                if (grp == LANES) begin
                    grp = 0;
                    held++;
                    chk("slot_limit", held <= DEPTH, 1'b1);
                end
            end
            if (instr_valid && instr_ready) begin
                chk("pop_has_word", held > 0, 1'b1);
                chk("pop_pc", instr_pc, epc);
                chk("pop_instr", instr, word_at(epc));
                epc = epc + 8'(LANES);
                held--;
                pops++;
            end
        end
    end

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'hA3; mem[2] = 8'h01; mem[3] = 8'h20;
        reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 8'h00;

        // reset values
        repeat (3) cyc();
        smp();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 8'h00);

        // first instruction from reset, consumer stalled
        cyc(); reset = 1'b0; fetch_en = 1'b1; smp();
        n = 0;
        while (!mem_req && n < 8) begin cyc(); smp(); n++; end
        chk("first_req_seen", mem_req, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("first_req_on", mem_req, 1'b1);
            chk("first_req_adr", mem_adr, 8'(k));
            cyc(); smp();
        end
        chk("second_lane0_req", mem_req, 1'b1);
        chk("valid_not_yet", instr_valid, 1'b0);
        cyc(); smp();
        chk("first_valid", instr_valid, 1'b1);
        chk("first_instr", instr, 32'h2001A38C);
        chk("first_pc", instr_pc, 8'h00);

        // queue fills to DEPTH, fetch waits; one pop releases the third fetch
        repeat (4) begin cyc(); smp(); end
        chk("wait_slot_req_low", mem_req, 1'b0);
        chk("wait_slot_valid", instr_valid, 1'b1);
        cyc(); instr_ready = 1'b1; smp();
        chk("pop_cycle_req_low", mem_req, 1'b0);
        cyc(); instr_ready = 1'b0; smp();
        chk("second_head_pc", instr_pc, 8'h04);
        cyc(); smp();
        chk("third_fetch_req", mem_req, 1'b1);
        chk("third_fetch_adr", mem_adr, 8'h08);

        // redirect together with ready while two words are queued
        repeat (6) begin cyc(); smp(); end
        chk("full_req_low", mem_req, 1'b0);
        chk("full_valid", instr_valid, 1'b1);
        cyc(); redirect = 1'b1; redirect_pc = 8'h80; instr_ready = 1'b1; smp();
        cyc(); redirect = 1'b0; smp();
        chk("flush_valid_low", instr_valid, 1'b0);
        chk("flush_req", mem_req, 1'b1);
        chk("flush_adr", mem_adr, 8'h80);
        n = 0;
        while (!instr_valid && n < 12) begin cyc(); smp(); n++; end
        chk("post_flush_pc", instr_pc, 8'h80);

        // redirect right after lane 2 of a word: its beats are discarded
        n = 0;
        while (!(mem_req && mem_adr == 8'h86) && n < 20) begin cyc(); smp(); n++; end
        chk("reach_lane2", mem_adr, 8'h86);
        cyc(); redirect = 1'b1; redirect_pc = 8'h40; smp();
        cyc(); redirect = 1'b0; smp();
        chk("r40_valid_low", instr_valid, 1'b0);
        chk("r40_adr", mem_adr, 8'h40);
        n = 0;
        while (!instr_valid && n < 12) begin cyc(); smp(); n++; end
        chk("r40_pc", instr_pc, 8'h40);
        chk("r40_instr", instr, word_at(8'h40));

        // redirect after a last-lane request, to a wrapping address
        n = 0;
        while (!(mem_req && mem_adr == 8'h47) && n < 20) begin cyc(); smp(); n++; end
        chk("reach_lane3", mem_adr, 8'h47);
        cyc(); redirect = 1'b1; redirect_pc = 8'hFE; smp();
        cyc(); redirect = 1'b0; smp();
        for (int k = 0; k < 4; k++) begin
            chk("wrap_adr", mem_adr, 8'(8'hFE + k));
            cyc(); smp();
        end
        n = 0;
        while (!instr_valid && n < 12) begin cyc(); smp(); n++; end
        chk("wrap_pc", instr_pc, 8'hFE);
        chk("wrap_instr", instr, word_at(8'hFE));
        cyc(); smp();
        n = 0;
        while (!instr_valid && n < 12) begin cyc(); smp(); n++; end
        chk("wrap_next_pc", instr_pc, 8'h02);

        // fetch_en dropped after lane 1: word completes, then fetch stops
        cyc(); redirect = 1'b1; redirect_pc = 8'h20; smp();
        cyc(); redirect = 1'b0; smp();
        chk("drop_lane0", mem_adr, 8'h20);
        cyc(); smp();
        cyc(); fetch_en = 1'b0; smp();
        chk("drop_lane2_req", mem_req, 1'b1);
        chk("drop_lane2_adr", mem_adr, 8'h22);
        cyc(); smp();
        chk("drop_lane3_req", mem_req, 1'b1);
        chk("drop_lane3_adr", mem_adr, 8'h23);
        seen = 1'b0;
        repeat (6) begin
            cyc(); smp();
            chk("drop_idle_req", mem_req, 1'b0);
            if (instr_valid) begin
                seen = 1'b1;
                chk("drop_pc", instr_pc, 8'h20);
            end
        end
        chk("drop_delivered", seen, 1'b1);

        // reset in the middle of an instruction
        cyc(); fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 8'h30; smp();
        cyc(); redirect = 1'b0; smp();
        cyc(); smp();
        cyc(); reset = 1'b1; smp();
        cyc(); reset = 1'b0; smp();
        chk("midrst_valid", instr_valid, 1'b0);
        chk("midrst_adr", mem_adr, RESET_PC);
        chk("midrst_req", mem_req, 1'b0);

        // randomized traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            fetch_en    = ($urandom % 8) != 0;
            instr_ready = ($urandom % 3) != 0;
            redirect    = ($urandom % 40) == 0;
            redirect_pc = 8'($urandom);
            reset       = ($urandom % 400) == 0;
            smp();
        end
        cyc(); reset = 1'b0; redirect = 1'b0; smp();
        chk("random_progress", pops > 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
